// File: rtl/blade_ignition_pkg.sv
// Shared types and constants for the blade ignition sequencer.
package blade_ignition_pkg;

  // Sequencer states; the encoding is visible on the state output.
  typedef enum logic [1:0] {
    ST_OFF        = 2'b00,
    ST_EXTENDING  = 2'b01,
    ST_ON         = 2'b10,
    ST_RETRACTING = 2'b11
  } state_e;

  localparam int CM_PER_M = 100;
  localparam int MAX_CM   = 100;

  // bladeConfig encodings
  localparam logic [1:0] CFG_NONE        = 2'b00;
  localparam logic [1:0] CFG_SINGLE      = 2'b01;
  localparam logic [1:0] CFG_DOUBLE      = 2'b10;
  localparam logic [1:0] CFG_DOUBLE_HILT = 2'b11;

  // True when the configuration lights the secondary emitter.
  function automatic logic cfg_is_double(input logic [1:0] cfg);
    return (cfg == CFG_DOUBLE) || (cfg == CFG_DOUBLE_HILT);
  endfunction

endpackage

// File: rtl/blade_ignition_len_split.sv
// Splits a centimetre position into meters and centimetre-remainder parts.
module len_split #(
  parameter int W = 16
) (
  input  logic [7:0]   i_pos_cm,
  output logic [W-1:0] o_cur_l,
  output logic [W-1:0] o_cur_r
);
  import blade_ignition_pkg::*;

  localparam logic [7:0] CM8 = 8'(CM_PER_M);

  // Constant divide/modulo by 100 on an 8-bit position.
  always_comb begin
    o_cur_l = W'(i_pos_cm / CM8);
    o_cur_r = W'(i_pos_cm % CM8);
  end

endmodule

// File: rtl/blade_ignition.sv
// Blade ignition sequencer: latches a target length on ignite and steps the
// blade position toward it, or back to zero on retract.
module blade_ignition #(
  parameter int W       = 16,
  parameter int STEP_CM = 1,
  parameter int MAX_CM  = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] lenL,
  input  logic [W-1:0] lenR,
  input  logic [1:0]   bladeConfig,
  input  logic         ignite,
  input  logic         retract,
  output logic [W-1:0] curL,
  output logic [W-1:0] curR,
  output logic [1:0]   state,
  output logic [1:0]   emitters,
  output logic         done,
  output logic         err
);
  import blade_ignition_pkg::*;

  localparam logic [7:0] STEP8 = 8'(STEP_CM);
  localparam logic [8:0] STEP9 = 9'(STEP_CM);

  state_e       r_state;
  state_e       w_state_nxt;
  logic [7:0]   r_pos;
  logic [7:0]   w_pos_nxt;
  logic [7:0]   r_tgt;
  logic [7:0]   w_tgt_nxt;
  logic [1:0]   r_cfg;
  logic [1:0]   w_cfg_nxt;
  logic         w_done_nxt;
  logic         w_err_nxt;

  logic [W+7:0] w_raw_cm;
  logic [7:0]   w_new_tgt;
  logic         w_reject;
  logic [8:0]   w_inc_sum;
  logic [7:0]   w_inc;
  logic [7:0]   w_dec;
  logic [7:0]   w_first;

  logic [W-1:0] w_cur_l;
  logic [W-1:0] w_cur_r;
  logic [W-1:0] r_cur_l;
  logic [W-1:0] r_cur_r;
  logic [1:0]   r_emit;
  logic         r_done;
  logic         r_err;

  // Candidate target from the live length inputs, plus the acceptance test.
  always_comb begin
    w_raw_cm = ((W+8)'(lenL) * (W+8)'(CM_PER_M)) + (W+8)'(lenR);
    if (w_raw_cm > (W+8)'(MAX_CM)) begin
      w_new_tgt = 8'(MAX_CM);
    end else begin
      w_new_tgt = w_raw_cm[7:0];
    end
    w_reject = lenL[W-1] | lenR[W-1] | (w_new_tgt == 8'd0) |
               (bladeConfig == CFG_NONE);
  end

  // One step up (clamped at the latched target) and one step down (clamped at 0).
  always_comb begin
    w_inc_sum = {1'b0, r_pos} + STEP9;
    if (w_inc_sum >= {1'b0, r_tgt}) begin
      w_inc = r_tgt;
    end else begin
      w_inc = w_inc_sum[7:0];
    end
    if (r_pos > STEP8) begin
      w_dec = r_pos - STEP8;
    end else begin
      w_dec = 8'd0;
    end
    if (STEP8 >= w_new_tgt) begin
      w_first = w_new_tgt;
    end else begin
      w_first = STEP8;
    end
  end

  // Next-state logic; retract takes priority over ignite everywhere.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_tgt_nxt   = r_tgt;
    w_cfg_nxt   = r_cfg;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_OFF: begin
        if (retract) begin
          w_state_nxt = ST_OFF;
        end else if (ignite) begin
          if (w_reject) begin
            w_err_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_EXTENDING;
            w_tgt_nxt   = w_new_tgt;
            w_cfg_nxt   = bladeConfig;
            w_pos_nxt   = w_first;
            w_done_nxt  = (w_first == w_new_tgt);
          end
        end else begin
          w_state_nxt = ST_OFF;
        end
      end
      ST_EXTENDING: begin
        if (retract) begin
          w_state_nxt = ST_RETRACTING;
          w_pos_nxt   = w_dec;
          w_done_nxt  = (w_dec == 8'd0);
        end else if (r_pos == r_tgt) begin
          w_state_nxt = ST_ON;
        end else begin
          w_pos_nxt  = w_inc;
          w_done_nxt = (w_inc == r_tgt);
        end
      end
      ST_ON: begin
        if (retract) begin
          w_state_nxt = ST_RETRACTING;
          w_pos_nxt   = w_dec;
          w_done_nxt  = (w_dec == 8'd0);
        end else begin
          w_state_nxt = ST_ON;
        end
      end
      ST_RETRACTING: begin
        if (!retract && ignite) begin
          w_state_nxt = ST_EXTENDING;
          w_pos_nxt   = w_inc;
          w_done_nxt  = (w_inc == r_tgt);
        end else if (r_pos == 8'd0) begin
          w_state_nxt = ST_OFF;
        end else begin
          w_pos_nxt  = w_dec;
          w_done_nxt = (w_dec == 8'd0);
        end
      end
      default: begin
        w_state_nxt = ST_OFF;
        w_pos_nxt   = 8'd0;
      end
    endcase
  end

  // Position in meters/centimetres derived from the next position.
  len_split #(.W(W)) u_len_split (
    .i_pos_cm (w_pos_nxt),
    .o_cur_l  (w_cur_l),
    .o_cur_r  (w_cur_r)
  );

  // FSM state, position, target and latched configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_OFF;
      r_pos   <= 8'd0;
      r_tgt   <= 8'd0;
      r_cfg   <= CFG_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_tgt   <= w_tgt_nxt;
      r_cfg   <= w_cfg_nxt;
    end
  end

  // Registered outputs so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_l <= '0;
      r_cur_r <= '0;
      r_emit  <= 2'b00;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_cur_l <= w_cur_l;
      r_cur_r <= w_cur_r;
      r_emit  <= {cfg_is_double(w_cfg_nxt) & (w_pos_nxt != 8'd0),
                  (w_pos_nxt != 8'd0)};
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign curL     = r_cur_l;
  assign curR     = r_cur_r;
  assign state    = r_state;
  assign emitters = r_emit;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_blade_ignition.sv
// Self-checking bench: a step-1 and a step-7 instance share stimulus.
module tb_blade_ignition;

  localparam logic [1:0] S_OFF = 2'b00;
  localparam logic [1:0] S_EXT = 2'b01;
  localparam logic [1:0] S_ON  = 2'b10;
  localparam logic [1:0] S_RET = 2'b11;

  logic        clk = 1'b0;
  logic        rst, ign, ret;
  logic [15:0] lenL, lenR;
  logic [1:0]  cfg;

  logic [15:0] cl1, cr1, cl7, cr7;
  logic [1:0]  st1, em1, st7, em7;
  logic        dn1, er1, dn7, er7;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic        ign;
    logic        ret;
    logic [15:0] l;
    logic [15:0] r;
    logic [1:0]  cfg;
    logic [1:0]  st;
    int          pos;
    logic [1:0]  em;
    logic        dn;
    logic        er;
  } vec_t;

  vec_t tbl[13];

  blade_ignition #(.W(16), .STEP_CM(1), .MAX_CM(100)) u_d1 (
    .clk(clk), .rst(rst), .lenL(lenL), .lenR(lenR), .bladeConfig(cfg),
    .ignite(ign), .retract(ret), .curL(cl1), .curR(cr1), .state(st1),
    .emitters(em1), .done(dn1), .err(er1)
  );

  blade_ignition #(.W(16), .STEP_CM(7), .MAX_CM(100)) u_d7 (
    .clk(clk), .rst(rst), .lenL(lenL), .lenR(lenR), .bladeConfig(cfg),
    .ignite(ign), .retract(ret), .curL(cl7), .curR(cr7), .state(st7),
    .emitters(em7), .done(dn7), .err(er7)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] e);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, e);
    end
  endtask

  // Compare every output of one instance against expectations; pos in cm.
  task automatic exp_out(input bit sel, input string nm, input logic [1:0] st,
                         input int pos, input logic [1:0] em, input logic dn,
                         input logic er);
    logic [15:0] a_cl, a_cr;
    logic [1:0]  a_st, a_em;
    logic        a_dn, a_er;
    if (sel) begin
      a_cl = cl7; a_cr = cr7; a_st = st7; a_em = em7; a_dn = dn7; a_er = er7;
    end else begin
      a_cl = cl1; a_cr = cr1; a_st = st1; a_em = em1; a_dn = dn1; a_er = er1;
    end
    chk({nm, ".state"},    32'(a_st), 32'(st));
    chk({nm, ".curL"},     32'(a_cl), 32'(pos / 100));
    chk({nm, ".curR"},     32'(a_cr), 32'(pos % 100));
    chk({nm, ".emitters"}, 32'(a_em), 32'(em));
    chk({nm, ".done"},     32'(a_dn), 32'(dn));
    chk({nm, ".err"},      32'(a_er), 32'(er));
  endtask

  task automatic do_reset;
    rst = 1'b1; ign = 1'b0; ret = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    int p;
    rst = 1'b1; ign = 1'b0; ret = 1'b0;
    lenL = 16'd0; lenR = 16'd0; cfg = 2'b00;

    // rst ign ret lenL lenR cfg | state pos emit done err  (step-1 instance)
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'd0,    2'b00, S_OFF, 0, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'd50,   2'b01, S_OFF, 0, 2'b00, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'd50,   2'b01, S_OFF, 0, 2'b00, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'd0,    2'b10, S_OFF, 0, 2'b00, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'd50,   2'b00, S_OFF, 0, 2'b00, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'd50,   2'b01, S_OFF, 0, 2'b00, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 2'b01, S_OFF, 0, 2'b00, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'd1,    2'b11, S_EXT, 1, 2'b11, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'd1,    2'b11, S_ON,  1, 2'b11, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'd80,   2'b00, S_ON,  1, 2'b11, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'd80,   2'b00, S_RET, 0, 2'b00, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'd80,   2'b00, S_OFF, 0, 2'b00, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'd80,   2'b00, S_OFF, 0, 2'b00, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst; ign = tbl[i].ign; ret = tbl[i].ret;
      lenL = tbl[i].l; lenR = tbl[i].r; cfg = tbl[i].cfg;
      tick;
      exp_out(1'b0, $sformatf("tbl%0d", i), tbl[i].st, tbl[i].pos,
              tbl[i].em, tbl[i].dn, tbl[i].er);
    end

    // Nominal single blade to 50 cm in 1 cm steps.
    do_reset;
    lenL = 16'd0; lenR = 16'd50; cfg = 2'b01; ign = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick;
      ign = 1'b0;
      exp_out(1'b0, $sformatf("nom_ext%0d", i), S_EXT, i, 2'b01, (i == 50), 1'b0);
    end
    tick;
    exp_out(1'b0, "nom_on", S_ON, 50, 2'b01, 1'b0, 1'b0);

    // Full-length double blade in 7 cm steps, then retract.
    do_reset;
    lenL = 16'd1; lenR = 16'd0; cfg = 2'b10; ign = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick;
      ign = 1'b0;
      p = (7 * i > 100) ? 100 : 7 * i;
      exp_out(1'b1, $sformatf("full_ext%0d", i), S_EXT, p, 2'b11, (p == 100), 1'b0);
    end
    tick;
    exp_out(1'b1, "full_on", S_ON, 100, 2'b11, 1'b0, 1'b0);
    ret = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick;
      ret = 1'b0;
      p = (100 - 7 * i < 0) ? 0 : 100 - 7 * i;
      exp_out(1'b1, $sformatf("full_ret%0d", i), S_RET, p,
              (p != 0) ? 2'b11 : 2'b00, (p == 0), 1'b0);
    end
    tick;
    exp_out(1'b1, "full_off", S_OFF, 0, 2'b00, 1'b0, 1'b0);

    // Saturation: 101 cm and 1 m + 1 cm both clamp to 100 cm.
    for (int k = 0; k < 2; k++) begin
      do_reset;
      lenL = (k == 0) ? 16'd0 : 16'd1;
      lenR = (k == 0) ? 16'd101 : 16'd1;
      cfg = 2'b01; ign = 1'b1;
      tick;
      ign = 1'b0;
      repeat (99) tick;
      exp_out(1'b0, $sformatf("sat%0d_top", k), S_EXT, 100, 2'b01, 1'b1, 1'b0);
      tick;
      exp_out(1'b0, $sformatf("sat%0d_on", k), S_ON, 100, 2'b01, 1'b0, 1'b0);
    end

    // Reversal: retract at 30 cm, re-ignite at 10 cm, back to the 60 cm target.
    do_reset;
    lenL = 16'd0; lenR = 16'd60; cfg = 2'b01; ign = 1'b1;
    tick;
    ign = 1'b0;
    repeat (29) tick;
    exp_out(1'b0, "rev_at30", S_EXT, 30, 2'b01, 1'b0, 1'b0);
    lenR = 16'd5;
    ret = 1'b1;
    tick;
    exp_out(1'b0, "rev_29", S_RET, 29, 2'b01, 1'b0, 1'b0);
    repeat (19) tick;
    exp_out(1'b0, "rev_10", S_RET, 10, 2'b01, 1'b0, 1'b0);
    ret = 1'b0; ign = 1'b1;
    tick;
    exp_out(1'b0, "rev_11", S_EXT, 11, 2'b01, 1'b0, 1'b0);
    ign = 1'b0;
    repeat (48) tick;
    exp_out(1'b0, "rev_59", S_EXT, 59, 2'b01, 1'b0, 1'b0);
    tick;
    exp_out(1'b0, "rev_60", S_EXT, 60, 2'b01, 1'b1, 1'b0);
    tick;
    exp_out(1'b0, "rev_on", S_ON, 60, 2'b01, 1'b0, 1'b0);
    ret = 1'b1;
    tick;
    ret = 1'b0;
    exp_out(1'b0, "rev_dn59", S_RET, 59, 2'b01, 1'b0, 1'b0);
    repeat (58) tick;
    exp_out(1'b0, "rev_dn1", S_RET, 1, 2'b01, 1'b0, 1'b0);
    tick;
    exp_out(1'b0, "rev_dn0", S_RET, 0, 2'b00, 1'b1, 1'b0);
    tick;
    exp_out(1'b0, "rev_off", S_OFF, 0, 2'b00, 1'b0, 1'b0);

    // Reset mid-extension at 40 cm.
    do_reset;
    lenL = 16'd0; lenR = 16'd60; cfg = 2'b10; ign = 1'b1;
    tick;
    ign = 1'b0;
    repeat (39) tick;
    exp_out(1'b0, "rst_at40", S_EXT, 40, 2'b11, 1'b0, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_out(1'b0, "rst_off", S_OFF, 0, 2'b00, 1'b0, 1'b0);
    tick;
    exp_out(1'b0, "rst_stay", S_OFF, 0, 2'b00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
